// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: time-shares one external combinational ALU between two requesters.
//
// A round-robin arbiter picks one pending requester while idle and latches its opcode
// and operands into holding registers. Those registers drive the ALU for a single execute
// cycle, and the result is captured into a response register. The response is held
// until the consumer accepts it. Only one transaction is in flight at a time.
//
// Ports:
//   clk, reset                    clock; synchronous active-high reset
//   reqN_valid / reqN_ready       request handshake for requester N (N = 0, 1)
//   reqN_op, reqN_a, reqN_b       opcode and operands of requester N
//   alu_op, alu_a, alu_b          registered opcode/operands driven to the shared ALU
//   alu_res                       combinational result returned by the ALU
//   rsp_valid / rsp_ready         response handshake
//   rsp_id                        requester that owns the response
//   rsp_data, rsp_zero            captured result and its zero flag
//   busy                          high while a transaction is in flight
module alu_share_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_res,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             id_q, id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_zero_q, rsp_zero_d;

  logic             grant_id;
  logic             accept;

  // Arbitration: a lone requester always wins; under contention the requester that
  // did not win last time is chosen, which yields strict alternation.
  always_comb begin
    grant_id = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant_q;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  always_comb begin
    req0_ready = (state_q == StIdle) && req0_valid && !grant_id;
    req1_ready = (state_q == StIdle) && req1_valid && grant_id;
    accept     = req0_ready || req1_ready;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_zero_d   = rsp_zero_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_d         = grant_id ? req1_op : req0_op;
          a_d          = grant_id ? req1_a  : req0_a;
          b_d          = grant_id ? req1_b  : req0_b;
          id_d         = grant_id;
          last_grant_d = grant_id;
          state_d      = StExec;
        end
      end
      StExec: begin
        // Holding registers have been stable at the ALU inputs for a full cycle.
        rsp_data_d  = alu_res;
        rsp_zero_d  = (alu_res == '0);
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
      rsp_zero_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_zero_q   <= rsp_zero_d;
    end
  end

  assign alu_op    = op_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_zero  = rsp_zero_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: directed scenarios followed by random traffic, all
// outputs compared each cycle against a transaction-level reference model.
module tb_alu_share_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready;
  logic [2:0]  req0_op;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready;
  logic [2:0]  req1_op;
  logic [31:0] req1_a, req1_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_res;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, busy;
  logic [31:0] rsp_data;

  always #5 clk = ~clk;

  alu_share_ctrl #(.WIDTH(32), .OPW(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_res    (alu_res),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_zero   (rsp_zero),
    .busy       (busy)
  );

  // Behavioural shared ALU; op 000 is AND.
  function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return a + b;
      3'd4:    return a - b;
      3'd5:    return a << b[4:0];
      3'd6:    return a >> b[4:0];
      default: return {31'd0, a < b};
    endcase
  endfunction

  assign alu_res = alu_f(alu_op, alu_a, alu_b);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: one transaction in flight; age counts cycles since acceptance.
  logic        m_pending = 1'b0;
  int          m_age     = 0;
  logic        m_last    = 1'b1;
  logic [2:0]  m_op      = '0;
  logic [31:0] m_a       = '0;
  logic [31:0] m_b       = '0;
  logic        m_id      = 1'b0;
  logic        m_rv      = 1'b0;
  logic [31:0] m_rd      = '0;
  logic        m_rid     = 1'b0;
  logic        m_rz      = 1'b1;
  logic        e_r0, e_r1;
  logic        acc0 = 1'b0;
  logic        acc1 = 1'b0;
  int          grants[$];

  task automatic compute_exp();
    e_r0 = 1'b0;
    e_r1 = 1'b0;
    if (!m_pending) begin
      if (req0_valid && req1_valid) begin
        if (m_last) e_r0 = 1'b1;
        else        e_r1 = 1'b1;
      end else if (req0_valid) begin
        e_r0 = 1'b1;
      end else if (req1_valid) begin
        e_r1 = 1'b1;
      end
    end
  endtask

  task automatic model_edge();
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (reset) begin
      m_pending = 1'b0; m_age = 0; m_last = 1'b1;
      m_op = '0; m_a = '0; m_b = '0; m_id = 1'b0;
      m_rv = 1'b0; m_rd = '0; m_rid = 1'b0; m_rz = 1'b1;
    end else if (!m_pending) begin
      if (e_r0 || e_r1) begin
        m_id      = e_r1;
        m_op      = e_r1 ? req1_op : req0_op;
        m_a       = e_r1 ? req1_a  : req0_a;
        m_b       = e_r1 ? req1_b  : req0_b;
        m_last    = e_r1;
        m_pending = 1'b1;
        m_age     = 1;
        acc0      = e_r0;
        acc1      = e_r1;
        grants.push_back(int'(e_r1));
      end
    end else if (m_age == 1) begin
      m_rd  = alu_f(m_op, m_a, m_b);
      m_rz  = (m_rd == 32'd0);
      m_rid = m_id;
      m_rv  = 1'b1;
      m_age = 2;
    end else if (rsp_ready) begin
      m_rv      = 1'b0;
      m_pending = 1'b0;
    end
  endtask

  // Called shortly after a negedge with inputs already driven.
  task automatic step();
    #1;
    compute_exp();
    check_eq("req0_ready", {31'd0, req0_ready}, {31'd0, e_r0});
    check_eq("req1_ready", {31'd0, req1_ready}, {31'd0, e_r1});
    check_eq("busy",       {31'd0, busy},       {31'd0, m_pending});
    check_eq("rsp_valid",  {31'd0, rsp_valid},  {31'd0, m_rv});
    check_eq("rsp_data",   rsp_data,            m_rd);
    check_eq("rsp_id",     {31'd0, rsp_id},     {31'd0, m_rid});
    check_eq("rsp_zero",   {31'd0, rsp_zero},   {31'd0, m_rz});
    check_eq("alu_a",      alu_a,               m_a);
    check_eq("alu_b",      alu_b,               m_b);
    check_eq("alu_op",     {29'd0, alu_op},     {29'd0, m_op});
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
    @(posedge clk);
    @(negedge clk);
    step();
    step();
    reset = 1'b0;
    step();

    // Single request from requester 0.
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 3'd0; req0_a = 32'hFFFF0000; req0_b = 32'h0F0F0F0F;
    #1 check_eq("single_ready", {31'd0, req0_ready}, 32'd1);
    step();
    req0_valid = 1'b0;
    step();
    #1;
    check_eq("single_valid", {31'd0, rsp_valid}, 32'd1);
    check_eq("single_data", rsp_data, 32'h0F0F0000);
    check_eq("single_id", {31'd0, rsp_id}, 32'd0);
    check_eq("single_zero", {31'd0, rsp_zero}, 32'd0);
    step();
    step();

    // Zero result from requester 1.
    req1_valid = 1'b1; req1_op = 3'd0; req1_a = 32'hAAAAAAAA; req1_b = 32'h55555555;
    step();
    req1_valid = 1'b0;
    step();
    #1;
    check_eq("zero_data", rsp_data, 32'h00000000);
    check_eq("zero_flag", {31'd0, rsp_zero}, 32'd1);
    check_eq("zero_id", {31'd0, rsp_id}, 32'd1);
    step();

    // Contention: both continuously valid for four transactions.
    grants.delete();
    req0_valid = 1'b1; req0_op = 3'd0; req0_a = 32'h12345678; req0_b = 32'hF0F0F0F0;
    req1_valid = 1'b1; req1_op = 3'd0; req1_a = 32'h87654321; req1_b = 32'h0FF00FF0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (acc0) begin req0_a = $urandom; req0_b = $urandom; end
      if (acc1) begin req1_a = $urandom; req1_b = $urandom; end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    check_eq("cont_count", grants.size(), 32'd4);
    for (int g = 0; g < 4 && g < grants.size(); g++) begin
      check_eq($sformatf("cont_grant%0d", g), grants[g], g % 2);
    end

    // Backpressure with a request from requester 1 raised and withdrawn during the response.
    grants.delete();
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 3'd2; req0_a = 32'hDEADBEEF; req0_b = 32'h0BADF00D;
    step();
    req0_valid = 1'b0;
    step();
    for (int c = 0; c < 5; c++) begin
      req1_valid = (c == 2);
      req1_a = 32'hCAFE0000; req1_b = 32'h0000CAFE;
      step();
    end
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    #1 check_eq("bp_idle", {31'd0, busy}, 32'd0);
    req0_valid = 1'b1; req0_op = 3'd3; req0_a = 32'd100; req0_b = 32'd23;
    step();
    req0_valid = 1'b0;
    step();
    step();
    check_eq("wd_count", grants.size(), 32'd2);
    if (grants.size() == 2) check_eq("wd_grant", grants[1], 32'd0);

    // Reset during execute, then a contest that requester 0 must win.
    req1_valid = 1'b1; req1_op = 3'd1; req1_a = 32'h11110000; req1_b = 32'h00002222;
    step();
    req1_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check_eq("rst_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_alu_a", alu_a, 32'd0);
    check_eq("rst_alu_b", alu_b, 32'd0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1 check_eq("rst_fair", {30'd0, req1_ready, req0_ready}, 32'd1);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    step();

    // Random traffic; a requester holds its payload while waiting, but may withdraw.
    for (int c = 0; c < 600; c++) begin
      rsp_ready = ($urandom_range(0, 9) < 7);
      if (!req0_valid || acc0 || ($urandom_range(0, 9) == 0)) begin
        req0_valid = $urandom_range(0, 1);
        req0_op = $urandom_range(0, 7); req0_a = $urandom; req0_b = $urandom;
        if ($urandom_range(0, 7) == 0) req0_b = ~req0_a;
      end
      if (!req1_valid || acc1 || ($urandom_range(0, 9) == 0)) begin
        req1_valid = $urandom_range(0, 1);
        req1_op = $urandom_range(0, 7); req1_a = $urandom; req1_b = $urandom;
        if ($urandom_range(0, 7) == 0) req1_b = ~req1_a;
      end
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
